// File: rtl/a09_input_port.sv
// -----------------------------------------------------------------------------
// a09_input_port
//
// Input-side counterpart of the A09 output register path. A bank of external
// switches is captured when a bouncy push button (Strobe) gives a debounced
// press. The captured value is held in InReg for the CPU until it is read.
//
// Parameters
//   DataWidth       width of InReg; pins are zero-extended into it
//   PinWidth        number of switch pins (PinWidth <= DataWidth)
//   DebounceCycles  consecutive stable samples needed on press and release (>= 2)
//   CntWidth        debounce counter width; must hold DebounceCycles-1
//
// Ports
//   Clk      in   system clock, rising edge
//   Reset    in   asynchronous, active-high; clears all state
//   Pins     in   raw switch inputs, asynchronous to Clk
//   Strobe   in   raw capture button, active-high, asynchronous, bouncy
//   In_Rd    in   one-cycle CPU read acknowledge
//   InReg    out  captured value {zeros, Pins}
//   Valid    out  InReg holds data the CPU has not read yet
//   Overrun  out  sticky: a capture happened while Valid was still set
//   Busy     out  debouncer is not idle
// -----------------------------------------------------------------------------
module a09_input_port #(
  parameter int DataWidth      = 16,
  parameter int PinWidth       = 8,
  parameter int DebounceCycles = 16,
  parameter int CntWidth       = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [PinWidth-1:0]  Pins,
  input  logic                 Strobe,
  input  logic                 In_Rd,
  output logic [DataWidth-1:0] InReg,
  output logic                 Valid,
  output logic                 Overrun,
  output logic                 Busy
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_e;

  localparam logic [CntWidth-1:0] CntLast = CntWidth'(DebounceCycles - 1);
  localparam logic [CntWidth-1:0] CntOne  = CntWidth'(1);

  // ---------------------------------------------------------------------------
  // Two-flop synchronisers. Pins travel through the same depth as Strobe so
  // the switch value captured lines up with the button sample that fired it.
  // ---------------------------------------------------------------------------
  logic [PinWidth-1:0] pins_meta_q, pins_sync_q;
  logic                strobe_meta_q, strobe_sync_q;

  // NOTE: every flop here resets asynchronously; Reset must clear outputs at
  // once, even mid-debounce, without waiting for a clock edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pins_meta_q   <= '0;
      pins_sync_q   <= '0;
      strobe_meta_q <= 1'b0;
      strobe_sync_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so each flop samples the previous
      // stage's old value; blocking here would collapse the chain to one flop.
      pins_meta_q   <= Pins;
      pins_sync_q   <= pins_meta_q;
      strobe_meta_q <= Strobe;
      strobe_sync_q <= strobe_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce FSM. The counter only runs in the two WAIT states and the state
  // is left on reaching CntLast, so it never wraps.
  // ---------------------------------------------------------------------------
  state_e              state_q;
  logic [CntWidth-1:0] cnt_q;
  logic                busy_q;
  logic                capture;

  // A press is accepted on the PRESS_WAIT -> HELD edge only; returning to
  // HELD from RELEASE_WAIT is a release bounce and never captures.
  assign capture = (state_q == PRESS_WAIT) && strobe_sync_q && (cnt_q == CntLast);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (strobe_sync_q) begin
            state_q <= PRESS_WAIT;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        PRESS_WAIT: begin
          if (!strobe_sync_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (cnt_q == CntLast) begin
            state_q <= HELD;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        HELD: begin
          if (!strobe_sync_q) begin
            state_q <= RELEASE_WAIT;
            cnt_q   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (strobe_sync_q) begin
            state_q <= HELD;
          end else if (cnt_q == CntLast) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Holding register and handshake flags.
  // ---------------------------------------------------------------------------
  logic [DataWidth-1:0] inreg_q, inreg_d;
  logic                 valid_q, valid_d;
  logic                 overrun_q, overrun_d;

  always_comb begin
    // NOTE: every output of this block is given its hold value first, so no
    // path through the branches below can leave one unassigned (no latches).
    inreg_d   = inreg_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (capture) begin
      inreg_d = DataWidth'(pins_sync_q);
      valid_d = 1'b1;
      // Unread data being replaced flags an overrun, unless the CPU reads it
      // on this very edge, in which case the old value counts as consumed.
      if (valid_q) begin
        overrun_d = !In_Rd;
      end
    end else if (In_Rd && valid_q) begin
      // InReg is deliberately kept; only the handshake flags drop.
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      inreg_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      inreg_q   <= inreg_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign InReg   = inreg_q;
  assign Valid   = valid_q;
  assign Overrun = overrun_q;
  assign Busy    = busy_q;

endmodule
